thirtytwo_bit_recursive_borrow_subtractor_piped: RTL and testbench

//  Pipelined WIDTH-bit unsigned/two's-complement subtractor: diff = a - b, computed as a + ~b + 1.

---
 rtl/thirtytwo_bit_recursive_borrow_subtractor_piped_if.sv | 39 +++
 rtl/thirtytwo_bit_recursive_borrow_subtractor_piped.sv | 102 ++++++++++
 tb/tb_thirtytwo_bit_recursive_borrow_subtractor_piped.sv | 258 +++++++++++++++++++++++++
 3 files changed

// File: rtl/thirtytwo_bit_recursive_borrow_subtractor_piped_if.sv
// Operand/result handshake bundle for the pipelined prefix subtractor.
// slave = subtractor side, master = producer/consumer side.
interface thirtytwo_bit_recursive_borrow_subtractor_piped_if #(
    parameter int unsigned WIDTH = 32
) ();
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] diff;
    logic             bout;
    logic             ovf;

    modport slave (
        input  in_valid,
        input  a,
        input  b,
        input  out_ready,
        output in_ready,
        output out_valid,
        output diff,
        output bout,
        output ovf
    );

    modport master (
        output in_valid,
        output a,
        output b,
        output out_ready,
        input  in_ready,
        input  out_valid,
        input  diff,
        input  bout,
        input  ovf
    );
endinterface

// File: rtl/thirtytwo_bit_recursive_borrow_subtractor_piped.sv
// Pipelined a - b (= a + ~b + 1) with a recursive-doubling carry prefix tree,
// one register per prefix level and a valid/ready stall-able pipeline.
module thirtytwo_bit_recursive_borrow_subtractor_piped #(
    parameter int unsigned WIDTH = 32
) (
    input  logic clk,
    input  logic clear_n,
    thirtytwo_bit_recursive_borrow_subtractor_piped_if.slave bus
);
    localparam int unsigned LOG2W = $clog2(WIDTH);

    logic             advance;
    logic [WIDTH-1:0] g0_c;
    logic [WIDTH-1:0] p0_c;

    // Stage registers: prefix G/P, original propagate, operand sign bits, valid.
    logic [WIDTH-1:0] g_s  [LOG2W];
    logic [WIDTH-1:0] p_s  [LOG2W];
    logic [WIDTH-1:0] po_s [LOG2W];
    logic [LOG2W-1:0] am_s;
    logic [LOG2W-1:0] bm_s;
    logic [LOG2W-1:0] v_s;

    // Prefix level k combines across distance 2^(k-1); the last level feeds the output stage.
    logic [WIDTH-1:0] lvl_g [1:LOG2W];
    logic [WIDTH-1:0] lvl_p [1:LOG2W-1];

    logic [WIDTH-1:0] carry_c;
    logic [WIDTH-1:0] diff_c;
    logic             bout_c;
    logic             ovf_c;

    assign advance     = ~bus.out_valid | bus.out_ready;
    assign bus.in_ready = advance;

    // Stage 0 generate/propagate on (a, ~b) with the +1 carry-in folded into bit 0.
    always_comb begin
        g0_c    = bus.a & ~bus.b;
        p0_c    = ~(bus.a ^ bus.b);
        g0_c[0] = g0_c[0] | p0_c[0];
    end

    for (genvar k = 1; k <= int'(LOG2W); k++) begin : g_lvl
        localparam int D = 1 << (k - 1);
        for (genvar i = 0; i < int'(WIDTH); i++) begin : g_bit
            if (i >= D) begin : g_comb
                assign lvl_g[k][i] = g_s[k-1][i] | (p_s[k-1][i] & g_s[k-1][i-D]);
            end else begin : g_pass
                assign lvl_g[k][i] = g_s[k-1][i];
            end
            if (k < int'(LOG2W)) begin : g_prop
                if (i >= D) begin : g_pcomb
                    assign lvl_p[k][i] = p_s[k-1][i] & p_s[k-1][i-D];
                end else begin : g_ppass
                    assign lvl_p[k][i] = p_s[k-1][i];
                end
            end
        end
    end

    // Final carries give the difference, borrow and signed overflow.
    always_comb begin
        carry_c = lvl_g[LOG2W];
        diff_c  = po_s[LOG2W-1] ^ {carry_c[WIDTH-2:0], 1'b1};
        bout_c  = ~carry_c[WIDTH-1];
        ovf_c   = (am_s[LOG2W-1] ^ bm_s[LOG2W-1]) & (diff_c[WIDTH-1] ^ am_s[LOG2W-1]);
    end

    // Whole pipe moves together on advance and freezes otherwise.
    always_ff @(posedge clk or negedge clear_n) begin
        if (!clear_n) begin
            v_s  <= '0;
            am_s <= '0;
            bm_s <= '0;
            for (int k = 0; k < int'(LOG2W); k++) begin
                g_s[k]  <= '0;
                p_s[k]  <= '0;
                po_s[k] <= '0;
            end
            bus.out_valid <= 1'b0;
            bus.diff      <= '0;
            bus.bout      <= 1'b0;
            bus.ovf       <= 1'b0;
        end else if (advance) begin
            v_s  <= {v_s[LOG2W-2:0], bus.in_valid};
            am_s <= {am_s[LOG2W-2:0], bus.a[WIDTH-1]};
            bm_s <= {bm_s[LOG2W-2:0], bus.b[WIDTH-1]};
            g_s[0]  <= g0_c;
            p_s[0]  <= p0_c;
            po_s[0] <= p0_c;
            for (int k = 1; k < int'(LOG2W); k++) begin
                g_s[k]  <= lvl_g[k];
                p_s[k]  <= lvl_p[k];
                po_s[k] <= po_s[k-1];
            end
            bus.out_valid <= v_s[LOG2W-1];
            bus.diff      <= v_s[LOG2W-1] ? diff_c : '0;
            bus.bout      <= v_s[LOG2W-1] & bout_c;
            bus.ovf       <= v_s[LOG2W-1] & ovf_c;
        end
    end
endmodule

// File: tb/tb_thirtytwo_bit_recursive_borrow_subtractor_piped.sv
// Directed bench for the pipelined prefix subtractor: latency, borrow/overflow,
// boundaries, streaming, back-pressure and mid-stream reset.
module tb_thirtytwo_bit_recursive_borrow_subtractor_piped;
    localparam int unsigned WIDTH = 32;

    logic clk;
    logic clear_n;

    thirtytwo_bit_recursive_borrow_subtractor_piped_if #(.WIDTH(WIDTH)) bus ();

    thirtytwo_bit_recursive_borrow_subtractor_piped #(.WIDTH(WIDTH)) u_dut (
        .clk     (clk),
        .clear_n (clear_n),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] d;
        logic        bo;
        logic        ov;
    } res_t;

    typedef struct packed {
        logic        ovld;
        logic        irdy;
        logic [31:0] d;
        logic        bo;
        logic        ov;
    } obs_t;

    int   n_checks;
    int   n_fail;
    res_t exp_q[$];

    // Reference result: borrow from unsigned compare, overflow from a 33-bit signed difference.
    function automatic res_t model(input logic [31:0] x, input logic [31:0] y);
        logic [32:0] sd;
        res_t        r;
        sd   = {x[31], x} - {y[31], y};
        r.d  = x - y;
        r.bo = (x < y);
        r.ov = (sd[32] != sd[31]);
        return r;
    endfunction

    // Drive one cycle's inputs at negedge and sample the registered outputs just after.
    task automatic step(input logic iv, input logic [31:0] x, input logic [31:0] y,
                        input logic ordy, output obs_t o);
        @(negedge clk);
        bus.in_valid  = iv;
        bus.a         = x;
        bus.b         = y;
        bus.out_ready = ordy;
        #1;
        o.ovld = bus.out_valid;
        o.irdy = bus.in_ready;
        o.d    = bus.diff;
        o.bo   = bus.bout;
        o.ov   = bus.ovf;
    endtask

    // Push one op into an idle pipe; lat counts sample points until the result is taken.
    task automatic run_one(input logic [31:0] x, input logic [31:0] y,
                           output res_t r, output int lat);
        obs_t o;
        lat = 0;
        r   = '0;
        step(1'b1, x, y, 1'b1, o);
        for (int k = 1; k <= 20; k++) begin
            step(1'b0, 32'h0, 32'h0, 1'b1, o);
            if (o.ovld) begin
                lat = k;
                r   = {o.d, o.bo, o.ov};
                break;
            end
        end
    endtask

    task automatic test_reset();
        obs_t o;
        bus.in_valid  = 1'b0;
        bus.a         = '0;
        bus.b         = '0;
        bus.out_ready = 1'b0;
        clear_n       = 1'b1;
        #1 clear_n    = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        o.ovld = bus.out_valid; o.irdy = bus.in_ready;
        o.d = bus.diff; o.bo = bus.bout; o.ov = bus.ovf;
        n_checks++; if (o.ovld !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid got %b want 0", o.ovld); end
        n_checks++; if (o.d !== 32'h0) begin n_fail++; $display("FAIL reset_diff got %h want 0", o.d); end
        n_checks++; if (o.bo !== 1'b0) begin n_fail++; $display("FAIL reset_bout got %b want 0", o.bo); end
        n_checks++; if (o.ov !== 1'b0) begin n_fail++; $display("FAIL reset_ovf got %b want 0", o.ov); end
        n_checks++; if (o.irdy !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready got %b want 1", o.irdy); end
        @(negedge clk);
        clear_n = 1'b1;
    endtask

    task automatic test_basic();
        res_t r; int lat;
        run_one(32'd5, 32'd3, r, lat);
        n_checks++; if (lat !== 6) begin n_fail++; $display("FAIL basic_latency got %0d want 6", lat); end
        n_checks++; if (r !== {32'd2, 1'b0, 1'b0}) begin n_fail++; $display("FAIL basic_5m3 got %h want %h", r, {32'd2, 1'b0, 1'b0}); end
    endtask

    task automatic test_borrow();
        res_t r; int lat;
        run_one(32'd3, 32'd5, r, lat);
        n_checks++; if (r !== {32'hFFFF_FFFE, 1'b1, 1'b0}) begin n_fail++; $display("FAIL borrow_3m5 got %h want %h", r, {32'hFFFF_FFFE, 1'b1, 1'b0}); end
        run_one(32'd0, 32'd1, r, lat);
        n_checks++; if (r !== {32'hFFFF_FFFF, 1'b1, 1'b0}) begin n_fail++; $display("FAIL borrow_0m1 got %h want %h", r, {32'hFFFF_FFFF, 1'b1, 1'b0}); end
    endtask

    task automatic test_overflow();
        res_t r; int lat;
        run_one(32'h8000_0000, 32'h1, r, lat);
        n_checks++; if (r !== {32'h7FFF_FFFF, 1'b0, 1'b1}) begin n_fail++; $display("FAIL ovf_min_m1 got %h want %h", r, {32'h7FFF_FFFF, 1'b0, 1'b1}); end
        run_one(32'h7FFF_FFFF, 32'hFFFF_FFFF, r, lat);
        n_checks++; if (r !== {32'h8000_0000, 1'b1, 1'b1}) begin n_fail++; $display("FAIL ovf_max_mneg1 got %h want %h", r, {32'h8000_0000, 1'b1, 1'b1}); end
    endtask

    task automatic test_boundaries();
        res_t r; int lat; obs_t o;
        run_one(32'h1234_5678, 32'h1234_5678, r, lat);
        n_checks++; if (r !== 34'h0) begin n_fail++; $display("FAIL bound_equal got %h want 0", r); end
        run_one(32'h0, 32'h0, r, lat);
        n_checks++; if (r !== 34'h0) begin n_fail++; $display("FAIL bound_zero got %h want 0", r); end
        run_one(32'hFFFF_FFFF, 32'hFFFF_FFFF, r, lat);
        n_checks++; if (r !== 34'h0) begin n_fail++; $display("FAIL bound_ones got %h want 0", r); end
        run_one(32'hFFFF_FFFF, 32'h0, r, lat);
        n_checks++; if (r !== {32'hFFFF_FFFF, 1'b0, 1'b0}) begin n_fail++; $display("FAIL bound_ones_m0 got %h want %h", r, {32'hFFFF_FFFF, 1'b0, 1'b0}); end
        // Once the result is consumed and nothing follows, outputs drop to zero.
        step(1'b0, 32'h0, 32'h0, 1'b1, o);
        n_checks++; if (o.ovld !== 1'b0) begin n_fail++; $display("FAIL bound_idle_valid got %b want 0", o.ovld); end
        n_checks++; if (o.d !== 32'h0) begin n_fail++; $display("FAIL bound_idle_diff got %h want 0", o.d); end
    endtask

    task automatic test_back_to_back();
        localparam int N = 1000;
        obs_t o; res_t e;
        logic [31:0] x, y;
        int pushed, got, first_c, last_c;
        pushed = 0; got = 0; first_c = -1; last_c = -1;
        exp_q.delete();
        for (int c = 0; c < N + 40; c++) begin
            x = $urandom();
            y = (c % 7 == 0) ? x : $urandom();
            step(pushed < N, x, y, 1'b1, o);
            if (o.ovld) begin
                if (exp_q.size() == 0) begin
                    n_checks++; n_fail++;
                    $display("FAIL b2b_extra got %h want none", {o.d, o.bo, o.ov});
                end else begin
                    e = exp_q.pop_front();
                    n_checks++;
                    if ({o.d, o.bo, o.ov} !== e) begin n_fail++; $display("FAIL b2b_result[%0d] got %h want %h", got, {o.d, o.bo, o.ov}, e); end
                end
                if (first_c < 0) first_c = c;
                last_c = c;
                got++;
            end
            if ((pushed < N) && o.irdy) begin
                exp_q.push_back(model(x, y));
                pushed++;
            end
        end
        n_checks++; if (got !== N) begin n_fail++; $display("FAIL b2b_count got %0d want %0d", got, N); end
        n_checks++; if (last_c - first_c + 1 !== N) begin n_fail++; $display("FAIL b2b_gapless got %0d want %0d", last_c - first_c + 1, N); end
        n_checks++; if (first_c !== 6) begin n_fail++; $display("FAIL b2b_fill got %0d want 6", first_c); end
    endtask

    task automatic test_stall();
        localparam int N = 20;
        obs_t o, held; res_t e;
        logic [31:0] x, y;
        logic ordy;
        int pushed, got, stall_left;
        logic stalled_done;
        pushed = 0; got = 0; stall_left = 0; stalled_done = 1'b0;
        held = '0;
        exp_q.delete();
        for (int c = 0; c < 80; c++) begin
            x = 32'h1000_0000 + 32'(c * 3);
            y = 32'h0F00_0000 + 32'(c * 17);
            ordy = (stall_left == 0);
            step(pushed < N, x, y, ordy, o);
            if (stall_left > 0) begin
                n_checks++; if (o.irdy !== 1'b0) begin n_fail++; $display("FAIL stall_in_ready got %b want 0", o.irdy); end
                if (stall_left == 3) held = o;
                else begin
                    n_checks++; if (o !== held) begin n_fail++; $display("FAIL stall_hold got %h want %h", o, held); end
                end
                stall_left--;
            end else if (o.ovld) begin
                if (exp_q.size() == 0) begin
                    n_checks++; n_fail++;
                    $display("FAIL stall_extra got %h want none", {o.d, o.bo, o.ov});
                end else begin
                    e = exp_q.pop_front();
                    n_checks++;
                    if ({o.d, o.bo, o.ov} !== e) begin n_fail++; $display("FAIL stall_result[%0d] got %h want %h", got, {o.d, o.bo, o.ov}, e); end
                end
                got++;
                if (!stalled_done) begin stalled_done = 1'b1; stall_left = 3; end
            end
            if ((pushed < N) && o.irdy) begin
                exp_q.push_back(model(x, y));
                pushed++;
            end
        end
        n_checks++; if (got !== N) begin n_fail++; $display("FAIL stall_count got %0d want %0d", got, N); end
    endtask

    task automatic test_reset_mid();
        obs_t o; res_t r; int lat; int stale;
        for (int k = 0; k < 7; k++) step(1'b1, 32'h100 + 32'(k), 32'h1, 1'b1, o);
        @(negedge clk);
        bus.in_valid = 1'b0;
        #2;
        n_checks++; if (bus.out_valid !== 1'b1) begin n_fail++; $display("FAIL rst_pre_valid got %b want 1", bus.out_valid); end
        clear_n = 1'b0;
        #1;
        n_checks++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL rst_async_valid got %b want 0", bus.out_valid); end
        n_checks++; if (bus.diff !== 32'h0) begin n_fail++; $display("FAIL rst_async_diff got %h want 0", bus.diff); end
        n_checks++; if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL rst_async_in_ready got %b want 1", bus.in_ready); end
        @(negedge clk);
        @(negedge clk);
        clear_n = 1'b1;
        stale = 0;
        for (int k = 0; k < 10; k++) begin
            step(1'b0, 32'h0, 32'h0, 1'b1, o);
            if (o.ovld) stale++;
        end
        n_checks++; if (stale !== 0) begin n_fail++; $display("FAIL rst_stale got %0d want 0", stale); end
        run_one(32'd9, 32'd4, r, lat);
        n_checks++; if (lat !== 6) begin n_fail++; $display("FAIL rst_after_latency got %0d want 6", lat); end
        n_checks++; if (r !== {32'd5, 1'b0, 1'b0}) begin n_fail++; $display("FAIL rst_after_result got %h want %h", r, {32'd5, 1'b0, 1'b0}); end
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        test_reset();
        test_basic();
        test_borrow();
        test_overflow();
        test_boundaries();
        test_back_to_back();
        test_stall();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
